png_chunk_crc: RTL and testbench

PNG_CHUNK_CRC -- requirements
Module: png_chunk_crc

---
 rtl/png_chunk_crc_pkg.sv | 32 +++
 rtl/png_chunk_crc_if.sv | 33 +++
 rtl/png_chunk_crc_step.sv | 28 ++
 rtl/png_chunk_crc.sv | 168 ++++++++++++++++
 tb/tb_png_chunk_crc.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/png_chunk_crc_pkg.sv
// Shared definitions for the PNG chunk CRC block: CRC-32 constants, FSM
// state encoding, well-known chunk type codes and the per-byte CRC update.
package png_chunk_crc_pkg;

    // Reflected CRC-32 polynomial used by PNG (same as zlib/Ethernet).
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOR  = 32'hFFFF_FFFF;

    // Chunk type codes, big-endian ASCII.
    localparam logic [31:0] TYPE_IHDR = 32'h4948_4452;
    localparam logic [31:0] TYPE_IDAT = 32'h4944_4154;
    localparam logic [31:0] TYPE_IEND = 32'h4945_4E44;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TYPE = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } state_t;

    // One byte through the reflected CRC: LSB-first shift, eight bit steps.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/png_chunk_crc_if.sv
// Handshake/data bundle for png_chunk_crc. The master side issues the chunk
// header and payload beats; the slave side is the CRC engine.
interface png_chunk_crc_if #(
    parameter int DATA_BYTES = 4,
    parameter int LEN_WD     = 32
);
    localparam int NUM_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic                    start_i;
    logic [31:0]             type_i;
    logic [LEN_WD-1:0]       len_i;
    logic                    val_i;
    logic                    rdy_o;
    logic [8*DATA_BYTES-1:0] dat_i;
    logic [NUM_W-1:0]        num_i;
    logic                    lst_i;
    logic                    busy_o;
    logic                    done_o;
    logic [31:0]             crc_o;
    logic [LEN_WD-1:0]       len_o;
    logic                    err_o;

    modport master (
        output start_i, type_i, len_i, val_i, dat_i, num_i, lst_i,
        input  rdy_o, busy_o, done_o, crc_o, len_o, err_o
    );

    modport slave (
        input  start_i, type_i, len_i, val_i, dat_i, num_i, lst_i,
        output rdy_o, busy_o, done_o, crc_o, len_o, err_o
    );

endinterface

// File: rtl/png_chunk_crc_step.sv
// crc32_step: combinational byte-parallel CRC-32 update. Bytes are taken
// MSB-first from data; only the first cnt bytes are folded in.
module crc32_step
    import png_chunk_crc_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int CNT_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic [31:0]             crc,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [CNT_W-1:0]        cnt,
    output logic [31:0]             nxt
);

    logic [31:0] acc;

    // Chain the per-byte update across the valid leading bytes.
    always_comb begin
        acc = crc;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (b < int'(cnt)) begin
                acc = crc_byte(acc, data[8*(DATA_BYTES-b)-1 -: 8]);
            end
        end
        nxt = acc;
    end

endmodule

// File: rtl/png_chunk_crc.sv
// png_chunk_crc: computes the PNG chunk CRC-32 over the 4 type bytes followed
// by the payload, and counts payload bytes.
// Optional feature: define PNG_CHUNK_LEN_CHECK_EN to compare the counted
// length with the declared length and pulse err_o alongside done_o.
module png_chunk_crc
    import png_chunk_crc_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int LEN_WD     = 32
) (
    input logic             clk,
    input logic             rst,
    png_chunk_crc_if.slave  bus
);

    localparam int CNT_W      = $clog2(DATA_BYTES + 1);
    // Type bytes consumed per TYPE cycle and number of TYPE cycles.
    localparam int TYPE_BYTES = (DATA_BYTES < 4) ? DATA_BYTES : 4;
    localparam int TYPE_BEATS = (DATA_BYTES < 4) ? (4 / DATA_BYTES) : 1;

    state_t                  st, st_nxt;
    logic [31:0]             crc_q;
    logic [31:0]             crc_res;
    logic [31:0]             type_sh;
    logic [1:0]              tcnt;
    logic [LEN_WD-1:0]       len_lat;
    logic [LEN_WD-1:0]       cnt_q;
    logic [LEN_WD-1:0]       cnt_nxt;
    logic [8*DATA_BYTES-1:0] type_beat;
    logic [8*DATA_BYTES-1:0] step_dat;
    logic [CNT_W-1:0]        step_cnt;
    logic [31:0]             crc_nxt;
    logic                    beat_acc;
    logic                    last_acc;
    logic                    type_last;

    // Type bytes are presented MSB-aligned; wide buses carry them in the top 4 bytes.
    if (DATA_BYTES > 4) begin : g_type_wide
        assign type_beat = {type_sh, {(8*DATA_BYTES-32){1'b0}}};
    end else begin : g_type_narrow
        assign type_beat = type_sh[31 -: 8*DATA_BYTES];
    end

    assign beat_acc  = (st == DATA) && bus.val_i;
    assign last_acc  = beat_acc && bus.lst_i;
    assign type_last = (st == TYPE) && (tcnt == 2'(TYPE_BEATS - 1));
    assign cnt_nxt   = cnt_q + LEN_WD'(step_cnt);

    // Select what feeds the CRC this cycle: type bytes in TYPE, payload in DATA.
    always_comb begin
        step_dat = bus.dat_i;
        step_cnt = CNT_W'(DATA_BYTES);
        if (st == TYPE) begin
            step_dat = type_beat;
            step_cnt = CNT_W'(TYPE_BYTES);
        end else if (bus.lst_i) begin
            step_cnt = CNT_W'(bus.num_i) + CNT_W'(1);
        end
    end

    crc32_step #(
        .DATA_BYTES (DATA_BYTES),
        .CNT_W      (CNT_W)
    ) u_step (
        .crc  (crc_q),
        .data (step_dat),
        .cnt  (step_cnt),
        .nxt  (crc_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        st_nxt     = st;
        bus.rdy_o  = 1'b0;
        bus.busy_o = 1'b1;
        bus.done_o = 1'b0;
        case (st)
            IDLE: begin
                bus.busy_o = 1'b0;
                if (bus.start_i) st_nxt = TYPE;
            end
            TYPE: begin
                if (type_last) st_nxt = (len_lat != '0) ? DATA : FIN;
            end
            DATA: begin
                bus.rdy_o = 1'b1;
                if (last_acc) st_nxt = FIN;
            end
            FIN: begin
                bus.done_o = 1'b1;
                st_nxt     = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // Running CRC, type shifter, byte counter and the held final result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q   <= CRC_INIT;
            crc_res <= '0;
            type_sh <= '0;
            tcnt    <= '0;
            len_lat <= '0;
            cnt_q   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.start_i) begin
                        crc_q   <= CRC_INIT;
                        type_sh <= bus.type_i;
                        tcnt    <= '0;
                        len_lat <= bus.len_i;
                        cnt_q   <= '0;
                    end
                end
                TYPE: begin
                    crc_q   <= crc_nxt;
                    type_sh <= type_sh << (8 * TYPE_BYTES);
                    tcnt    <= tcnt + 2'd1;
                    if (type_last && (len_lat == '0)) crc_res <= crc_nxt ^ CRC_XOR;
                end
                DATA: begin
                    if (beat_acc) begin
                        crc_q <= crc_nxt;
                        cnt_q <= cnt_nxt;
                        if (bus.lst_i) crc_res <= crc_nxt ^ CRC_XOR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.crc_o = crc_res;
    assign bus.len_o = cnt_q;

`ifdef PNG_CHUNK_LEN_CHECK_EN
    logic err_q;

    // Flag a declared/counted length mismatch on the cycle the chunk closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (last_acc) begin
            err_q <= (cnt_nxt != len_lat);
        end else if ((st == TYPE) && type_last && (len_lat == '0)) begin
            err_q <= (cnt_q != len_lat);
        end else begin
            err_q <= 1'b0;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_png_chunk_crc.sv
// Scoreboard bench for png_chunk_crc: one 4-byte-wide and one 1-byte-wide
// instance driven with directed PNG chunks (IHDR of a 1x1 RGBA image, IEND).
module tb_png_chunk_crc;
    import png_chunk_crc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    png_chunk_crc_if #(.DATA_BYTES(4), .LEN_WD(32)) b4 ();
    png_chunk_crc_if #(.DATA_BYTES(1), .LEN_WD(32)) b1 ();

    png_chunk_crc #(.DATA_BYTES(4), .LEN_WD(32)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    png_chunk_crc #(.DATA_BYTES(1), .LEN_WD(32)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        string       nm;
        logic [31:0] crc;
        logic [31:0] len;
        logic        err;
        bit          chk_crc;
        int          due;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    bit hold4 = 0, hold1 = 0;
    logic [31:0] hcrc4, hlen4, hcrc1, hlen1;
    string hnm4, hnm1;

    // IHDR payload: width 1, height 1, depth 8, colour 6, comp 0, filter 0, interlace 0.
    logic [7:0] pay [13] = '{8'h00, 8'h00, 8'h00, 8'h01,
                             8'h00, 8'h00, 8'h00, 8'h01,
                             8'h08, 8'h06, 8'h00, 8'h00, 8'h00};

`ifdef PNG_CHUNK_LEN_CHECK_EN
    localparam logic SHORT_ERR = 1'b1;
`else
    localparam logic SHORT_ERR = 1'b0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Monitor: counts negedges and checks every done_o pulse against the queues.
    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            if (hold4) begin
                hold4 = 0;
                chk({hnm4, "_hold_crc"}, b4.crc_o, hcrc4);
                chk({hnm4, "_hold_len"}, b4.len_o, hlen4);
            end
            if (b4.err_o) chk("err4_with_done", b4.done_o, 1);
            if (b4.done_o) begin
                if (q4.size() == 0) begin
                    chk("done4_unexpected", b4.done_o, 0);
                end else begin
                    e4 = q4.pop_front();
                    if (e4.chk_crc) chk({e4.nm, "_crc"}, b4.crc_o, e4.crc);
                    chk({e4.nm, "_len"}, b4.len_o, e4.len);
                    chk({e4.nm, "_err"}, b4.err_o, e4.err);
                    if (e4.due >= 0) chk({e4.nm, "_latency"}, ncyc, e4.due);
                    hold4 = 1;
                    hnm4  = e4.nm;
                    hcrc4 = e4.chk_crc ? e4.crc : b4.crc_o;
                    hlen4 = e4.len;
                end
            end
            if (hold1) begin
                hold1 = 0;
                chk({hnm1, "_hold_crc"}, b1.crc_o, hcrc1);
                chk({hnm1, "_hold_len"}, b1.len_o, hlen1);
            end
            if (b1.done_o) begin
                if (q1.size() == 0) begin
                    chk("done1_unexpected", b1.done_o, 0);
                end else begin
                    e1 = q1.pop_front();
                    chk({e1.nm, "_crc"}, b1.crc_o, e1.crc);
                    chk({e1.nm, "_len"}, b1.len_o, e1.len);
                    chk({e1.nm, "_err"}, b1.err_o, e1.err);
                    if (e1.due >= 0) chk({e1.nm, "_latency"}, ncyc, e1.due);
                    hold1 = 1;
                    hnm1  = e1.nm;
                    hcrc1 = e1.crc;
                    hlen1 = e1.len;
                end
            end
        end
    end

    task automatic idle_start4(input logic [31:0] typ, input logic [31:0] len, output int s);
        int n;
        n = 0;
        @(negedge clk);
        while (b4.busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b4.busy_o) chk("start4_wait_idle", b4.busy_o, 0);
        b4.start_i = 1'b1;
        b4.type_i  = typ;
        b4.len_i   = len;
        @(posedge clk);
        #1 b4.start_i = 1'b0;
        s = ncyc;
    endtask

    task automatic beats4(input int nbytes, input int maxgap, input bit poke_start);
        int nb, g, n;
        bit ok;
        logic [31:0] d;
        nb = (nbytes + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            b4.val_i = 1'b0;
            for (int j = 0; j < g; j++) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < 4; k++) d[31-8*k -: 8] = (4*i + k < nbytes) ? pay[4*i + k] : 8'hA5;
            b4.dat_i = d;
            b4.lst_i = (i == nb - 1);
            b4.num_i = (i == nb - 1) ? 2'((nbytes - 1) % 4) : 2'd0;
            b4.val_i = 1'b1;
            if (poke_start && i == 0) begin
                b4.start_i = 1'b1;
                b4.type_i  = 32'hDEAD_BEEF;
            end
            ok = 0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = b4.rdy_o;
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) chk("beat4_accept", ok, 1);
            b4.start_i = 1'b0;
        end
        b4.val_i = 1'b0;
        b4.lst_i = 1'b0;
    endtask

    task automatic chunk4(input string nm, input logic [31:0] typ, input int len, input int nbytes,
                          input int maxgap, input bit poke, input logic [31:0] crc,
                          input bit chk_crc, input logic err);
        int s;
        exp_t e;
        idle_start4(typ, len, s);
        e.nm = nm; e.crc = crc; e.len = nbytes; e.err = err; e.chk_crc = chk_crc;
        if (nbytes == 0) begin
            e.due = s + 2;
            q4.push_back(e);
        end else begin
            beats4(nbytes, maxgap, poke);
            e.due = ncyc + 1;
            q4.push_back(e);
        end
    endtask

    task automatic chunk1(input string nm, input logic [31:0] typ, input int nbytes,
                          input logic [31:0] crc);
        int s, n;
        bit ok;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (b1.busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b1.busy_o) chk("start1_wait_idle", b1.busy_o, 0);
        b1.start_i = 1'b1;
        b1.type_i  = typ;
        b1.len_i   = nbytes;
        @(posedge clk);
        #1 b1.start_i = 1'b0;
        s = ncyc;
        e.nm = nm; e.crc = crc; e.len = nbytes; e.err = 1'b0; e.chk_crc = 1;
        if (nbytes == 0) begin
            e.due = s + 5;
            q1.push_back(e);
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                b1.dat_i = pay[i];
                b1.lst_i = (i == nbytes - 1);
                b1.num_i = 1'b0;
                b1.val_i = 1'b1;
                ok = 0;
                n  = 0;
                while (!ok && n < 100) begin
                    @(negedge clk);
                    ok = b1.rdy_o;
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (!ok) chk("beat1_accept", ok, 1);
            end
            b1.val_i = 1'b0;
            b1.lst_i = 1'b0;
            e.due = ncyc + 1;
            q1.push_back(e);
        end
    endtask

    initial begin
        int s, n;
        bit ok;
        b4.start_i = 0; b4.type_i = 0; b4.len_i = 0; b4.val_i = 0;
        b4.dat_i = 0; b4.num_i = 0; b4.lst_i = 0;
        b1.start_i = 0; b1.type_i = 0; b1.len_i = 0; b1.val_i = 0;
        b1.dat_i = 0; b1.num_i = 0; b1.lst_i = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy",  b4.rdy_o,  0);
        chk("reset_busy", b4.busy_o, 0);
        chk("reset_done", b4.done_o, 0);
        chk("reset_err",  b4.err_o,  0);
        chk("reset_crc",  b4.crc_o,  0);
        chk("reset_len",  b4.len_o,  0);
        rst = 1'b0;

        chunk1("iend_b1", TYPE_IEND, 0,  32'hAE42_6082);
        chunk1("ihdr_b1", TYPE_IHDR, 13, 32'h1F15_C489);

        chunk4("iend_b4", TYPE_IEND, 0, 0, 0, 0, 32'hAE42_6082, 1, 1'b0);
        chunk4("ihdr_b4", TYPE_IHDR, 13, 13, 0, 0, 32'h1F15_C489, 1, 1'b0);
        for (int r = 0; r < 3; r++)
            chunk4("ihdr_gap", TYPE_IHDR, 13, 13, 3, (r == 0), 32'h1F15_C489, 1, 1'b0);

        chunk4("b2b_ihdr", TYPE_IHDR, 13, 13, 0, 0, 32'h1F15_C489, 1, 1'b0);
        chunk4("b2b_iend", TYPE_IEND, 0, 0, 0, 0, 32'hAE42_6082, 1, 1'b0);

        chunk4("short", TYPE_IHDR, 13, 12, 0, 0, 32'h0, 0, SHORT_ERR);

        // Abort an IHDR chunk mid-payload with reset.
        idle_start4(TYPE_IHDR, 13, s);
        b4.dat_i = 32'h0000_0001;
        b4.num_i = 2'd0;
        b4.lst_i = 1'b0;
        b4.val_i = 1'b1;
        ok = 0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = b4.rdy_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("rst_beat_accept", ok, 1);
        @(negedge clk);
        chk("rst_pre_busy", b4.busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", b4.busy_o, 0);
        chk("rst_mid_rdy",  b4.rdy_o,  0);
        chk("rst_mid_crc",  b4.crc_o,  0);
        chk("rst_mid_len",  b4.len_o,  0);
        b4.val_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        chunk4("iend_after_rst", TYPE_IEND, 0, 0, 0, 0, 32'hAE42_6082, 1, 1'b0);

        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_q4", q4.size(), 0);
        chk("drain_q1", q1.size(), 0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
